motoro_dead_time: RTL and testbench

Three-phase dead-time inserter and shoot-through guard between the motor commutation logic and the gate-driver pins. It takes the six raw high/low phase requests and re-times them, so that a high-side and a low-side switch of one phase are never on together. It also guarantees a programmable both-off gap on every transition and flags illegal requests.

---
 rtl/motoro_dead_time.sv | 126 ++++++++++++
 tb/tb_motoro_dead_time.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/motoro_dead_time.sv
// Three-phase dead-time inserter with shoot-through guard and illegal-request flag.
// Optional macro MOTORO_FAULT_LATCH_EN: sticky fault that forces every phase off until faultClr.
module motoro_dead_time #(
  parameter int DEAD_CYC = 50,
  parameter int CNT_W    = 8
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       drvEn,
  input  logic       faultClr,
  input  logic       aHreq,
  input  logic       aLreq,
  input  logic       bHreq,
  input  logic       bLreq,
  input  logic       cHreq,
  input  logic       cLreq,
  output logic       aH,
  output logic       aL,
  output logic       bH,
  output logic       bL,
  output logic       cH,
  output logic       cL,
  output logic [2:0] deadAct,
  output logic       fault
);

  // One-hot so each gate drive is a single flop bit and cannot glitch.
  typedef enum logic [2:0] {
    ST_OFF   = 3'b001,
    ST_DRV_H = 3'b010,
    ST_DRV_L = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] DEAD = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [2:0]       h_req;
  logic [2:0]       l_req;
  logic [2:0]       illegal;
  logic             fault_block;
  logic             fault_q;
  logic             fault_d;
  state_t           state_q [3];
  state_t           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];

  assign h_req   = {cHreq, bHreq, aHreq};
  assign l_req   = {cLreq, bLreq, aLreq};
  assign illegal = h_req & l_req;

`ifdef MOTORO_FAULT_LATCH_EN
  // A new illegal request wins over a simultaneous clear.
  assign fault_d     = (|illegal) | (fault_q & ~faultClr);
  assign fault_block = fault_q;
`else
  logic fault_clr_unused;
  assign fault_clr_unused = faultClr;
  assign fault_d          = |illegal;
  assign fault_block      = 1'b0;
`endif

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      fault_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      fault_q <= fault_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if ((cnt_q[i] >= DEAD) && drvEn && !fault_block && (h_req[i] ^ l_req[i])) begin
            state_d[i] = h_req[i] ? ST_DRV_H : ST_DRV_L;
          end else if (fault_block) begin
            cnt_d[i] = ONE;
          end else if (cnt_q[i] < DEAD) begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        ST_DRV_H: begin
          if (!(h_req[i] && !l_req[i]) || !drvEn || fault_block) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = ONE;
          end
        end
        ST_DRV_L: begin
          if (!(l_req[i] && !h_req[i]) || !drvEn || fault_block) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = ONE;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = ONE;
        end
      endcase
    end
  end

  always_comb begin
    aH = state_q[0][1];
    aL = state_q[0][2];
    bH = state_q[1][1];
    bL = state_q[1][2];
    cH = state_q[2][1];
    cL = state_q[2][2];
    for (int i = 0; i < 3; i++) begin
      deadAct[i] = state_q[i][0] && (cnt_q[i] < DEAD);
    end
    fault = fault_q;
  end

endmodule

// File: tb/tb_motoro_dead_time.sv
// Bench for motoro_dead_time: directed scenarios plus randomized requests against a reference model.
module tb_motoro_dead_time;

  localparam int D = 50;
`ifdef MOTORO_FAULT_LATCH_EN
  localparam bit LATCHED = 1'b1;
`else
  localparam bit LATCHED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       drvEn;
  logic       faultClr;
  logic [2:0] hreq;
  logic [2:0] lreq;
  logic       aH, aL, bH, bL, cH, cL;
  logic [2:0] deadAct;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: per phase the side being driven (0 none, 1 high, 2 low)
  // and the number of cycles it has spent switched off.
  int side [3];
  int offc [3];
  bit mfault;

  always #10 clk = ~clk;

  motoro_dead_time #(.DEAD_CYC(D), .CNT_W(8)) dut (
    .clk50mhz(clk), .reset(reset), .drvEn(drvEn), .faultClr(faultClr),
    .aHreq(hreq[0]), .aLreq(lreq[0]), .bHreq(hreq[1]), .bLreq(lreq[1]),
    .cHreq(hreq[2]), .cLreq(lreq[2]),
    .aH(aH), .aL(aL), .bH(bH), .bL(bL), .cH(cH), .cL(cL),
    .deadAct(deadAct), .fault(fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit blk;
    int want;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin side[i] = 0; offc[i] = 0; end
      mfault = 1'b0;
      return;
    end
    blk = LATCHED && mfault;
    for (int i = 0; i < 3; i++) begin
      if (hreq[i] && !lreq[i])      want = 1;
      else if (lreq[i] && !hreq[i]) want = 2;
      else                          want = 0;
      if (side[i] == 0) begin
        if (offc[i] >= D && drvEn && !blk && want != 0) side[i] = want;
        else offc[i] = blk ? 1 : offc[i] + 1;
      end else if (want != side[i] || !drvEn || blk) begin
        side[i] = 0;
        offc[i] = 1;
      end
    end
    if (LATCHED) mfault = (|(hreq & lreq)) || (mfault && !faultClr);
    else         mfault = |(hreq & lreq);
  endtask

  function automatic logic [9:0] model_vec();
    logic [9:0] v;
    for (int i = 0; i < 3; i++) begin
      v[9 - 2*i] = (side[i] == 1);
      v[8 - 2*i] = (side[i] == 2);
      v[1 + i]   = (side[i] == 0) && (offc[i] < D);
    end
    v[0] = mfault;
    return v;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {aH, aL, bH, bL, cH, cL, deadAct, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  initial begin
    int n;
    reset = 1'b1; drvEn = 1'b0; faultClr = 1'b0; hreq = '0; lreq = '0;
    tick(); tick();
    check_eq("reset_state", 32'(dut_vec()), 32'b00_0000_111_0);

    // Power-up: first drive after the full dead window.
    reset = 1'b0; drvEn = 1'b1; hreq = 3'b001;
    n = 0;
    do begin tick(); n++; end while (!aH && n < 200);
    check_eq("first_drive_cycles", 32'(n), 32'd51);
    check_eq("first_drive_others", 32'({aL, bH, bL, cH, cL}), 32'd0);

    // Direct H->L request change.
    hreq = 3'b000; lreq = 3'b001;
    tick();
    check_eq("h2l_h_off", 32'({aH, aL}), 32'd0);
    n = 0;
    do begin
      tick(); n++;
      if (!aL) check_eq("h2l_both_low", 32'({aH, aL}), 32'd0);
    end while (!aL && n < 200);
    check_eq("h2l_gap", 32'(n), 32'd50);

    // One-cycle illegal request on phase C while A drives low.
    hreq[2] = 1'b1; lreq[2] = 1'b1;
    tick();
    check_eq("illegal_fault", 32'(fault), 32'd1);
    check_eq("illegal_aL_same", 32'(aL), 32'd1);
    hreq[2] = 1'b0; lreq[2] = 1'b0;
    tick();
    if (LATCHED) begin
      check_eq("latch_fault_held", 32'(fault), 32'd1);
      check_eq("latch_aL_drop", 32'(aL), 32'd0);
      repeat (5) tick();
      faultClr = 1'b1;
      tick();
      faultClr = 1'b0;
      check_eq("latch_cleared", 32'(fault), 32'd0);
      n = 0;
      do begin tick(); n++; end while (!aL && n < 200);
      check_eq("latch_recover", 32'(n), 32'd50);
    end else begin
      check_eq("pulse_fault_clear", 32'(fault), 32'd0);
      check_eq("pulse_aL_kept", 32'(aL), 32'd1);
    end

    // All three phases driving, then drvEn dropped for 10 cycles.
    hreq = 3'b010; lreq = 3'b101;
    repeat (60) tick();
    check_eq("all_driving", 32'({aH, aL, bH, bL, cH, cL}), 32'b01_10_01);
    drvEn = 1'b0;
    tick();
    check_eq("drven_drop", 32'({aH, aL, bH, bL, cH, cL}), 32'd0);
    n = 0;
    repeat (9) begin tick(); n++; end
    drvEn = 1'b1;
    do begin tick(); n++; end while ({aH, aL, bH, bL, cH, cL} == 6'd0 && n < 200);
    check_eq("drven_return", 32'(n), 32'd50);

    // Reset while driving.
    reset = 1'b1;
    tick();
    check_eq("reset_mid", 32'(dut_vec()), 32'b00_0000_111_0);
    reset = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 6000; c++) begin
      faultClr = ($urandom_range(0, 49) == 0);
      reset    = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 299) == 0) drvEn = ~drvEn;
      for (int i = 0; i < 3; i++) begin
        if (hreq[i] && lreq[i]) begin
          hreq[i] = 1'b0; lreq[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 45)      begin hreq[i] = 1'b1; lreq[i] = 1'b0; end
          else if (r < 90) begin hreq[i] = 1'b0; lreq[i] = 1'b1; end
          else if (r < 99) begin hreq[i] = 1'b0; lreq[i] = 1'b0; end
          else             begin hreq[i] = 1'b1; lreq[i] = 1'b1; end
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
